// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: state encoding, product codes,
// coin request bundle and price lookup.
package vend_pkg;

    localparam int CRED_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PAY  = 2'd1;
    localparam logic [1:0] S_DISP = 2'd2;
    localparam logic [1:0] S_CHG  = 2'd3;

    localparam logic [3:0] P0 = 4'b0001;
    localparam logic [3:0] P1 = 4'b0010;
    localparam logic [3:0] P2 = 4'b0100;
    localparam logic [3:0] P3 = 4'b1000;

    typedef struct packed {
        logic cancel;
        logic coin2;
        logic coin1;
    } pay_req_t;

    function automatic logic [CRED_W-1:0] price_of(input logic [3:0] oh,
                                                   input int p0, input int p1,
                                                   input int p2, input int p3);
        logic [CRED_W-1:0] p;
        case (oh)
            P0:      p = CRED_W'(p0);
            P1:      p = CRED_W'(p1);
            P2:      p = CRED_W'(p2);
            P3:      p = CRED_W'(p3);
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Selection/coin inputs and vend outputs of the controller, bundled.
interface vend_controller_if #(parameter int CREDIT_W = 4);
    logic [3:0]          sel;
    logic                coin1;
    logic                coin2;
    logic                cancel;
    logic [3:0]          selected;
    logic [CREDIT_W-1:0] credit;
    logic [3:0]          dispense;
    logic                change_pulse;
    logic                coin_reject;
    logic                busy;

    modport master (output sel, coin1, coin2, cancel,
                    input  selected, credit, dispense, change_pulse, coin_reject, busy);
    modport slave  (input  sel, coin1, coin2, cancel,
                    output selected, credit, dispense, change_pulse, coin_reject, busy);
endinterface

// File: rtl/vend_controller_hold_timer.sv
// Loadable down-counter: after load, done rises once CYCLES cycles have elapsed.
module hold_timer #(
    parameter int CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic done
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           cnt <= '0;
        else if (load)        cnt <= W'(CYCLES - 1);
        else if (cnt != '0)   cnt <= cnt - W'(1);
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: latch selection, collect coins, dispense for a fixed time,
// then pay change one pulse per unit.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE0      = 2,
    parameter int PRICE1      = 3,
    parameter int PRICE2      = 4,
    parameter int PRICE3      = 5,
    parameter int CREDIT_W    = 4,
    parameter int DISP_CYCLES = 8,
    parameter int CHG_CYCLES  = 4
) (
    input  logic              clock,
    input  logic              reset,
    vend_controller_if.slave  bus
);
    logic [1:0]          state_q, state_d;
    logic [3:0]          sel_q, sel_d, disp_q, disp_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, chg_q, chg_d, price;
    logic                pulse_q, pulse_d, rej_q, rej_d, busy_q;
    logic                disp_load, chg_load, disp_done, chg_done;
    logic [CREDIT_W:0]   tot;
    logic                ovf, any_coin;
    pay_req_t            req;

    assign req      = '{cancel: bus.cancel, coin2: bus.coin2, coin1: bus.coin1};
    assign any_coin = req.coin1 | req.coin2;
    assign price    = CREDIT_W'(price_of(sel_q, PRICE0, PRICE1, PRICE2, PRICE3));
    // {coin2,coin1} is already the coin value: 1, 2 or 3 units
    assign tot      = {1'b0, credit_q} + (CREDIT_W+1)'({req.coin2, req.coin1});
    assign ovf      = tot[CREDIT_W];

    hold_timer #(.CYCLES(DISP_CYCLES)) u_disp_tmr (
        .clock(clock), .reset(reset), .load(disp_load), .done(disp_done));
    hold_timer #(.CYCLES(CHG_CYCLES)) u_chg_tmr (
        .clock(clock), .reset(reset), .load(chg_load), .done(chg_done));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        credit_d  = credit_q;
        chg_d     = chg_q;
        disp_d    = disp_q;
        pulse_d   = pulse_q;
        rej_d     = any_coin;
        disp_load = 1'b0;
        chg_load  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ($onehot(bus.sel)) begin
                    sel_d   = bus.sel;
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                if (req.cancel) begin
                    chg_d    = credit_q;
                    credit_d = '0;
                    sel_d    = '0;
                    if (credit_q != '0) begin
                        state_d  = S_CHG;
                        pulse_d  = 1'b1;
                        chg_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    rej_d    = any_coin & ovf;
                    credit_d = ovf ? credit_q : tot[CREDIT_W-1:0];
                    // coins arriving on the paid cycle still count toward change
                    if (credit_q >= price) begin
                        chg_d     = credit_d - price;
                        credit_d  = '0;
                        disp_d    = sel_q;
                        disp_load = 1'b1;
                        state_d   = S_DISP;
                    end
                end
            end
            S_DISP: begin
                if (disp_done) begin
                    disp_d = '0;
                    sel_d  = '0;
                    if (chg_q != '0) begin
                        state_d  = S_CHG;
                        pulse_d  = 1'b1;
                        chg_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CHG: begin
                if (pulse_q) begin
                    if (chg_done) pulse_d = 1'b0;
                end else begin
                    chg_d = chg_q - CREDIT_W'(1);
                    if (chg_q == CREDIT_W'(1)) begin
                        state_d = S_IDLE;
                    end else begin
                        pulse_d  = 1'b1;
                        chg_load = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            credit_q <= '0;
            chg_q    <= '0;
            disp_q   <= '0;
            pulse_q  <= 1'b0;
            rej_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            credit_q <= credit_d;
            chg_q    <= chg_d;
            disp_q   <= disp_d;
            pulse_q  <= pulse_d;
            rej_q    <= rej_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

    assign bus.selected     = sel_q;
    assign bus.credit       = credit_q;
    assign bus.dispense     = disp_q;
    assign bus.change_pulse = pulse_q;
    assign bus.coin_reject  = rej_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: session-level model feeds expected rejects,
// dispenses and change pulses into queues; a monitor pops and compares.
module tb_vend_controller;
    localparam int DISP = 8;
    localparam int CHG  = 4;
    localparam int CW   = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    vend_controller_if #(.CREDIT_W(CW)) b();

    vend_controller #(
        .PRICE0(2), .PRICE1(3), .PRICE2(4), .PRICE3(5),
        .CREDIT_W(CW), .DISP_CYCLES(DISP), .CHG_CYCLES(CHG)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    int prices[4] = '{2, 3, 4, 5};

    int         rej_q[$];
    logic [3:0] disp_q[$];
    int         chg_q[$];
    logic [2:0] prog[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic miss(input string nm, input int act);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected nothing (cycle %0d)", nm, act, cyc);
    endtask

    task automatic drive(input logic [2:0] c);
        b.cancel = c[2];
        b.coin2  = c[1];
        b.coin1  = c[0];
    endtask

    function automatic logic [2:0] rand_code();
        logic [2:0] c;
        c[0] = ($urandom_range(2) == 0);
        c[1] = ($urandom_range(2) == 0);
        c[2] = ($urandom_range(15) == 0);
        return c;
    endfunction

    // monitor: every observed reject / dispense run / change pulse consumes one expectation
    initial begin
        int dlen, clen;
        logic [3:0] dval;
        dlen = 0; clen = 0; dval = '0;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                dlen = 0; clen = 0;
            end else begin
                if (b.coin_reject) begin
                    if (rej_q.size() == 0) miss("reject_unexpected", cyc);
                    else chk("reject_cycle", cyc, rej_q.pop_front());
                end
                if (b.dispense != '0) begin
                    if (dlen == 0) dval = b.dispense;
                    else if (b.dispense != dval) chk("dispense_stable", int'(b.dispense), int'(dval));
                    dlen++;
                end else if (dlen > 0) begin
                    if (disp_q.size() == 0) miss("dispense_unexpected", int'(dval));
                    else begin
                        chk("dispense_value", int'(dval), int'(disp_q.pop_front()));
                        chk("dispense_len", dlen, DISP);
                    end
                    dlen = 0;
                end
                if (b.change_pulse) clen++;
                else if (clen > 0) begin
                    if (chg_q.size() == 0) miss("change_unexpected", clen);
                    else chk("change_len", clen, chg_q.pop_front());
                    clen = 0;
                end
            end
        end
    end

    // one purchase attempt; called and returns at a negedge
    task automatic run_session(input logic [3:0] s, input bit rnd);
        int pr, cr, idx, n, k, sum;
        bit done, paid;
        logic [2:0] c;
        pr = 0;
        for (int i = 0; i < 4; i++) if (s[i]) pr = prices[i];
        b.sel = s;
        c = (rnd && $urandom_range(3) == 0) ? 3'b001 : 3'b000;
        drive(c);
        if (c[0]) rej_q.push_back(cyc + 1);
        @(negedge clock);
        b.sel = '0;
        drive(3'b000);
        chk("selected", int'(b.selected), int'(s));
        chk("busy_pay", int'(b.busy), 1);
        chk("credit_start", int'(b.credit), 0);
        cr = 0; idx = 0; n = 0; done = 1'b0;
        while (!done) begin
            if (idx < prog.size()) begin c = prog[idx]; idx++; end
            else if (rnd) c = rand_code();
            else c = 3'b000;
            if (n >= 40) c = 3'b100;
            n++;
            drive(c);
            if (c[2]) begin
                if (c[1] | c[0]) rej_q.push_back(cyc + 1);
                for (int u = 0; u < cr; u++) chg_q.push_back(CHG);
                cr = 0;
                done = 1'b1;
            end else begin
                sum  = int'(c[0]) + 2 * int'(c[1]);
                paid = (cr >= pr);
                if (sum > 0) begin
                    if (cr + sum > (1 << CW) - 1) rej_q.push_back(cyc + 1);
                    else cr += sum;
                end
                if (paid) begin
                    disp_q.push_back(s);
                    for (int u = 0; u < cr - pr; u++) chg_q.push_back(CHG);
                    cr = 0;
                    done = 1'b1;
                end
            end
            @(negedge clock);
            drive(3'b000);
            chk("credit", int'(b.credit), cr);
        end
        k = 0;
        while (b.busy && k < 300) begin
            if (rnd) begin
                c = rand_code();
                drive(c);
                if (c[1] | c[0]) rej_q.push_back(cyc + 1);
            end
            @(negedge clock);
            drive(3'b000);
            k++;
        end
        chk("drain_in_time", int'(k < 300), 1);
        chk("idle_busy", int'(b.busy), 0);
        chk("idle_selected", int'(b.selected), 0);
        chk("idle_credit", int'(b.credit), 0);
        chk("idle_dispense", int'(b.dispense), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises, k, extra;
        bit prev;
        b.sel = '0;
        drive(3'b000);
        repeat (2) @(negedge clock);
        chk("rst_busy", int'(b.busy), 0);
        chk("rst_selected", int'(b.selected), 0);
        chk("rst_credit", int'(b.credit), 0);
        chk("rst_dispense", int'(b.dispense), 0);
        chk("rst_change", int'(b.change_pulse), 0);
        chk("rst_reject", int'(b.coin_reject), 0);
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clock);

        // coin in IDLE
        drive(3'b001);
        rej_q.push_back(cyc + 1);
        @(negedge clock);
        drive(3'b000);
        chk("idle_coin_credit", int'(b.credit), 0);
        chk("idle_coin_busy", int'(b.busy), 0);
        // multi-hot and empty selections are ignored
        b.sel = 4'b0011;
        @(negedge clock);
        b.sel = 4'b0000;
        chk("multihot_busy", int'(b.busy), 0);
        chk("multihot_selected", int'(b.selected), 0);
        @(negedge clock);
        chk("nosel_busy", int'(b.busy), 0);

        prog = {3'b010, 3'b010};         run_session(4'b0100, 1'b0);
        prog = {3'b010, 3'b001};         run_session(4'b0001, 1'b0);
        prog = {3'b011, 3'b010};         run_session(4'b1000, 1'b0);
        prog = {3'b010, 3'b101};         run_session(4'b0010, 1'b0);
        prog = {3'b010};                 run_session(4'b0001, 1'b1);
        prog.delete();
        repeat (30) run_session(4'(1 << $urandom_range(3)), 1'b1);

        // reset during the second of three refund pulses
        mon_en = 1'b0;
        b.sel = 4'b0001;
        @(negedge clock);
        b.sel = '0;
        drive(3'b011);
        @(negedge clock);
        drive(3'b100);
        @(negedge clock);
        drive(3'b000);
        rises = 0; prev = 1'b0; k = 0;
        while (k < 100) begin
            if (b.change_pulse && !prev) rises++;
            prev = b.change_pulse;
            if (rises == 2) break;
            @(negedge clock);
            k++;
        end
        chk("second_pulse_seen", rises, 2);
        #2 reset = 1'b0;
        #1;
        chk("arst_change", int'(b.change_pulse), 0);
        chk("arst_busy", int'(b.busy), 0);
        chk("arst_selected", int'(b.selected), 0);
        chk("arst_credit", int'(b.credit), 0);
        chk("arst_dispense", int'(b.dispense), 0);
        @(negedge clock);
        reset = 1'b1;
        rej_q.delete(); disp_q.delete(); chg_q.delete();
        extra = 0;
        repeat (30) begin
            @(negedge clock);
            if (b.change_pulse) extra++;
        end
        chk("pending_change_dropped", extra, 0);
        chk("post_rst_busy", int'(b.busy), 0);
        mon_en = 1'b1;
        prog = {3'b011, 3'b010}; run_session(4'b1000, 1'b0);

        repeat (3) @(negedge clock);
        chk("rej_left", rej_q.size(), 0);
        chk("disp_left", disp_q.size(), 0);
        chk("chg_left", chg_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
